// File: rtl/conv2d_pkg.sv
// Shared definitions for the conv2d front end: controller state encoding and
// default image geometry.
package conv2d_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } lb_state_e;

  localparam int DEF_IMG_W = 34;
  localparam int DEF_IMG_H = 34;

endpackage

// File: rtl/rc_counter.sv
// Column/row raster counter: col wraps at IMG_W-1 and bumps row; the whole
// position wraps to (0,0) after the last pixel of the frame.
module rc_counter
  import conv2d_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic                       inc,
  output logic [$clog2(IMG_W)-1:0]   col,
  output logic [$clog2(IMG_H)-1:0]   row,
  output logic                       last_col,
  output logic                       last_pix
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;

  assign last_col = (r_col == CW'(IMG_W - 1));
  assign last_pix = last_col && (r_row == RW'(IMG_H - 1));
  assign col      = r_col;
  assign row      = r_row;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_col <= '0;
      r_row <= '0;
    end else if (clear) begin
      r_col <= '0;
      r_row <= '0;
    end else if (inc) begin
      if (last_col) begin
        r_col <= '0;
        r_row <= last_pix ? '0 : r_row + RW'(1);
      end else begin
        r_col <= r_col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/linebuffer_ctrl.sv
// Line-buffer controller: paces pixel acceptance into a 2-row line buffer and
// flags when the 2x2 window is complete. No pixel data passes through here.
module linebuffer_ctrl
  import conv2d_pkg::*;
#(
  parameter int IMG_W = DEF_IMG_W,
  parameter int IMG_H = DEF_IMG_H
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       lb_enable,
  output logic                       win_valid,
  output logic [$clog2(IMG_W)-1:0]   col,
  output logic [$clog2(IMG_H)-1:0]   row,
  output logic                       busy,
  output logic                       frame_done
);

  localparam int RW = $clog2(IMG_H);

  lb_state_e r_state;
  lb_state_e w_nextState;
  logic      w_accept;
  logic      w_clear;
  logic      w_lastCol;
  logic      w_lastPix;
  logic      w_fillDone;
  logic      r_winValid;

  assign w_accept   = in_valid && in_ready;
  assign w_clear    = (r_state == ST_IDLE) && start;
  assign w_fillDone = w_accept && (row == RW'(1)) && (col == '0);
  assign lb_enable  = w_accept;
  assign win_valid  = r_winValid;

  rc_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_rcCounter (
    .clk      (clk),
    .reset    (reset),
    .clear    (w_clear),
    .inc      (w_accept),
    .col      (col),
    .row      (row),
    .last_col (w_lastCol),
    .last_pix (w_lastPix)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // FILL holds until the first pixel of row 1 lands, so the lower window row exists.
  always_comb begin
    w_nextState = r_state;
    in_ready    = 1'b0;
    busy        = 1'b1;
    frame_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) w_nextState = ST_FILL;
      end
      ST_FILL: begin
        in_ready = 1'b1;
        if (w_fillDone) w_nextState = ST_RUN;
      end
      ST_RUN: begin
        in_ready = 1'b1;
        if (w_accept && w_lastPix) w_nextState = ST_DONE;
      end
      ST_DONE: begin
        frame_done  = 1'b1;
        w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // A window completes when a pixel from row>=1, col>=1 is shifted in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_winValid <= 1'b0;
    end else begin
      r_winValid <= w_accept && (row != '0) && (col != '0);
    end
  end

  logic w_unusedLastCol;
  assign w_unusedLastCol = w_lastCol;

endmodule

// File: doc/linebuffer_ctrl.md
LINEBUFFER_CTRL -- requirements
Module: linebuffer_ctrl

Interface
REQ-001 SHALL have parameter IMG_W, default 34: pixels per image row; legal range 2..1024.
REQ-002 SHALL have parameter IMG_H, default 34: rows per frame; legal range 2..1024.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset is asynchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: a one-cycle pulse that begins one frame.
REQ-006 SHALL have port in_valid, input, 1 bit: the upstream pixel is present.
REQ-007 SHALL have port in_ready, output, 1 bit: the controller can accept a pixel this cycle.
REQ-008 SHALL have port lb_enable, output, 1 bit: shift the line buffer by one pixel this cycle.
REQ-009 SHALL have port win_valid, output, 1 bit: the 2x2 line-buffer window holds a complete window.
REQ-010 SHALL have port col, output, $clog2(IMG_W) bits: column index of the next pixel to accept.
REQ-011 SHALL have port row, output, $clog2(IMG_H) bits: row index of the next pixel to accept.
REQ-012 SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-013 SHALL have port frame_done, output, 1 bit: one-cycle pulse at the end of a frame.

Function
REQ-014 SHALL implement the states IDLE, FILL, RUN and DONE.
REQ-015 SHALL go from IDLE to FILL on start=1; start SHALL be ignored in every other state.
REQ-016 SHALL drive in_ready=1 only in FILL and RUN; accept is defined as in_valid & in_ready.
REQ-017 SHALL drive lb_enable = accept combinationally; with in_valid=0 there is no shift and no counter change.
REQ-018 SHALL advance col on each accept; at IMG_W-1, col wraps to 0 and row increments.
REQ-019 SHALL go from FILL to RUN on the accept of pixel index IMG_W, i.e. row=1 and col=0, which is IMG_W+1 accepted pixels.
REQ-020 SHALL register win_valid as accept & (row>=1) & (col>=1), so it is high the cycle after the accepting edge; column-0 pixels produce no window.
REQ-021 SHALL emit exactly (IMG_W-1)*(IMG_H-1) win_valid pulses per frame.
REQ-022 SHALL go from RUN to DONE on the accept of row=IMG_H-1, col=IMG_W-1, with in_ready=0 in the following cycle.
REQ-023 SHALL in DONE drive frame_done=1 for exactly one cycle, coincident with the last win_valid, then go to IDLE with row and col at 0.
REQ-024 SHALL drive busy=1 in FILL, RUN and DONE, and 0 in IDLE.
REQ-025 SHALL let start=1 and in_valid=1 in the same IDLE cycle accept no pixel; the first accept is possible one cycle later.
REQ-026 SHALL keep win_valid low in the cycle after a stall; stalls add no bubbles beyond the missing pixels themselves.

Reset
REQ-027 SHALL on reset=0, immediately and regardless of clk, force state IDLE, row=0, col=0, win_valid=0, frame_done=0, in_ready=0, lb_enable=0 and busy=0.
REQ-028 SHALL on reset mid-frame discard the partial frame; after release the block waits for a new start.

Structure
REQ-029 SHALL place the state enumeration and the default IMG_W/IMG_H constants in the shared package conv2d_pkg.
REQ-030 SHALL implement the col/row wrap counter as sub-module rc_counter, with inputs clk, reset, clear and inc and outputs col, row, last_col and last_pix.
REQ-031 SHALL contain no datapath; the 32-bit pixels bypass this block straight into the line buffer.

Verification
REQ-032 Reset: IMG_W=4, IMG_H=3, start pulse, 5 continuous pixels -> 0 win_valid pulses; after the accept that enters RUN, the 6th pixel (row 1, col 1) gives win_valid=1 one cycle later.
REQ-033 Full frame: IMG_W=4, IMG_H=3, 12 back-to-back pixels -> 6 win_valid pulses; frame_done with the 6th; in_ready=0 after the 12th accept; busy=0 one cycle after frame_done.
REQ-034 Stalls: the same frame with in_valid toggling 1,0,1,0 -> still 6 windows; lb_enable pulses equal 12; no win_valid in any cycle that follows a stall.
REQ-035 Reset mid-frame: assert reset=0 after 7 accepts -> all outputs 0 asynchronously; new start plus 12 pixels -> 6 windows, with row/col starting at 0.
REQ-036 Start ignored: start pulse while in RUN -> no change to row, col or the window count; start in the same cycle as in_valid in IDLE -> no pixel accepted.
REQ-037 Defaults: IMG_W=34, IMG_H=34, one full frame -> 1089 win_valid pulses, RUN entered after 35 accepts, one frame_done.
